// File: rtl/ibex_rf_wb_buffer.sv
// Writeback buffer in front of the flip-flop register file write port.
// Completed writebacks are queued in order and drained into the file only
// while it is not stalling. Queued values are forwarded to the ID read ports
// so reads never see stale data while writes are held off.
module ibex_rf_wb_buffer #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_valid_i,
  output logic                         wb_ready_o,
  input  logic [4:0]                   wb_addr_i,
  input  logic [DataWidth-1:0]         wb_data_i,
  input  logic                         rf_stall_i,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_waddr_o,
  output logic [DataWidth-1:0]         rf_wdata_o,
  input  logic [4:0]                   raddr_a_i,
  input  logic [4:0]                   raddr_b_i,
  output logic                         fwd_a_hit_o,
  output logic [DataWidth-1:0]         fwd_a_data_o,
  output logic                         fwd_b_hit_o,
  output logic [DataWidth-1:0]         fwd_b_data_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  typedef struct packed {
    logic                 valid;
    logic [4:0]           addr;
    logic [DataWidth-1:0] data;
  } entry_t;

  entry_t          mem [Depth];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;

  logic push, drop, enq, pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CntW'(Depth));
  assign count_o    = count_q;
  assign wb_ready_o = ~full_o;

  // x0 and (on RV32E) x16..x31 are accepted but never stored
  assign push = wb_valid_i & wb_ready_o;
  assign drop = (wb_addr_i == 5'd0) | (RV32E & wb_addr_i[4]);
  assign enq  = push & ~drop;

  // A reset edge discards everything, so never claim a write on it
  assign rf_we_o    = ~empty_o & ~rf_stall_i & ~rst_i;
  assign pop        = rf_we_o;
  assign rf_waddr_o = empty_o ? 5'd0 : mem[head_q].addr;
  assign rf_wdata_o = empty_o ? '0   : mem[head_q].data;

  // Storage, pointers and occupancy; data payload needs no reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) mem[i].valid <= 1'b0;
    end else begin
      if (enq) begin
        mem[tail_q] <= '{valid: 1'b1, addr: wb_addr_i, data: wb_data_i};
        tail_q      <= tail_q + 1'b1;
      end
      // enq and pop never target the same slot: pop needs non-empty,
      // enq needs non-full, so equal pointers rule one of them out
      if (pop) begin
        mem[head_q].valid <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  logic [1:0][4:0]           raddr;
  logic [1:0]                hit;
  logic [1:0][DataWidth-1:0] fdata;

  assign raddr = {raddr_b_i, raddr_a_i};

  // Forward lookup: scan oldest to youngest so the youngest match wins
  always_comb begin
    logic [PtrW-1:0] idx;
    idx   = '0;
    hit   = '0;
    fdata = '0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < Depth; k++) begin
        idx = head_q + PtrW'(k);
        if (raddr[p] != 5'd0 && mem[idx].valid && mem[idx].addr == raddr[p]) begin
          hit[p]   = 1'b1;
          fdata[p] = mem[idx].data;
        end
      end
    end
  end

  assign fwd_a_hit_o  = hit[0];
  assign fwd_a_data_o = fdata[0];
  assign fwd_b_hit_o  = hit[1];
  assign fwd_b_data_o = fdata[1];

endmodule

// File: doc/ibex_rf_wb_buffer.md
Name: ibex_rf_wb_buffer

Overview:
- Writeback buffer directly upstream of the flip-flop register file's write port.
- Queues completed writebacks from the WB stage in a small in-order FIFO and drains them into the register file's write port (waddr/wdata/we) only while the file's stall output is low.
- Forwards the youngest pending value for any register still queued, so ID-stage reads never observe stale data while writes are held off by a stall.

Parameters:
- Depth, 4: number of buffer entries; power of two, >= 2.
- DataWidth, 32: register data width.
- RV32E, 0: when 1, only registers x0..x15 are legal write targets.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- wb_valid_i  in  1  writeback request valid.
- wb_ready_o  out  1  buffer can accept a request this cycle.
- wb_addr_i  in  5  destination register.
- wb_data_i  in  DataWidth  writeback data.
- rf_stall_i  in  1  stall from the register file (its reg_stall_o); blocks draining.
- rf_we_o  out  1  register file write enable (we_a_i).
- rf_waddr_o  out  5  register file write address (waddr_a_i).
- rf_wdata_o  out  DataWidth  register file write data (wdata_a_i).
- raddr_a_i  in  5  ID read address A (same value the file sees).
- raddr_b_i  in  5  ID read address B.
- fwd_a_hit_o  out  1  A matches a buffered entry.
- fwd_a_data_o  out  DataWidth  forwarded data for A.
- fwd_b_hit_o  out  1  B matches a buffered entry.
- fwd_b_data_o  out  DataWidth  forwarded data for B.
- count_o  out  $clog2(Depth+1)  current occupancy.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == Depth.

Behaviour:
- Storage and pointers:
  - Circular FIFO, Depth entries of {valid, addr[4:0], data}.
  - Head (read) and tail (write) pointers, $clog2(Depth) bits, wrap modulo Depth.
  - Separate occupancy counter.
- Reset (rst_i high at a rising edge):
  - Pointers, count and all entry valid bits go to 0.
  - Outputs while and after reset until the first push: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, fwd_*_hit_o=0, fwd_*_data_o=0, count_o=0, empty_o=1, full_o=0, wb_ready_o=1.
  - Reset mid-operation discards all queued writes; nothing drains on that edge.
- Push:
  - wb_ready_o = !full_o, registered-state only; no same-cycle dependence on a pop.
  - Push fires when wb_valid_i & wb_ready_o.
  - Entry written at tail, tail increments.
- Drop:
  - Requests with wb_addr_i==0, or RV32E=1 with wb_addr_i[4]==1, are handshaken (consume wb_ready_o) but not enqueued.
  - Count and tail are unchanged.
- Drain:
  - rf_we_o = !empty_o & !rf_stall_i (combinational).
  - rf_waddr_o/rf_wdata_o present the head entry whenever it is non-empty, 0 when empty.
  - When rf_we_o=1 the head entry is popped at that edge.
  - While rf_stall_i=1 the head is held indefinitely with rf_we_o=0.
- Latency: a request accepted in cycle N appears on the rf_* port no earlier than N+1. There is no empty-bypass path.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full with pop: still not ready that cycle (wb_ready_o=0). Ready returns the following cycle.
- Ordering:
  - Strict FIFO.
  - Multiple entries for the same register are all kept and drained in order; no coalescing.
- Forwarding (combinational on raddr_*_i and buffer state):
  - hit = raddr != 0 and some valid entry has a matching addr.
  - data = the youngest matching entry (closest to tail); 0 when there is no hit.
  - The head entry being drained in the current cycle still forwards; after the edge the register file holds it.
  - The incoming wb_data_i is never forwarded.
- Occupancy flags: count_o, empty_o and full_o are derived from the registered count only.

Test Plan:
- Reset, then push x5=0xDEADBEEF with rf_stall_i=0:
  - Cycle N+1: rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF.
  - Cycle N+2: empty_o=1, rf_we_o=0.
- Hold rf_stall_i=1, push x1..x4 (data 0x11..0x44):
  - full_o=1, wb_ready_o=0, count_o=4; a fifth valid is not accepted.
  - Release stall: writes x1,x2,x3,x4 on four consecutive cycles, in order.
- Stall held, push x7=0xA then x7=0xB, set raddr_a_i=7, raddr_b_i=0:
  - fwd_a_hit_o=1, fwd_a_data_o=0xB; fwd_b_hit_o=0.
  - After both drain: fwd_a_hit_o=0.
- Push to x0, and with RV32E=1 push to x20:
  - Both handshaken; count_o stays 0; rf_we_o never asserts.
- With count_o=2, stall low, push every cycle for 8 cycles:
  - count_o stays 2; the rf_* sequence equals the push order delayed by 2 drains.
  - Pointers wrap correctly past Depth.
- Fill 3 entries with stall high, assert rst_i for one cycle, then release stall:
  - count_o=0, empty_o=1, no rf_we_o pulse, forwarding hits are 0.
